// File: rtl/tl_flow_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// tl_flow_ctrl_pkg
// Shared definitions for the transaction-layer flow controller, its FIFO
// neighbours and its testbench.
//   - default data / threshold widths and the destination-select bit
//   - state encodings (3-bit, numerically fixed: RESET=0 .. ERROR=4)
//   - fwd_t: one forwarded word together with its destination
//   - pause_forced(): states in which the main FIFO must always be paused
// -----------------------------------------------------------------------------
package tl_flow_ctrl_pkg;

    localparam int DEF_BITNUMBER = 8;
    localparam int DEF_LENGTH    = 8;
    localparam int DEF_DEST_BIT  = 4;
    localparam int CNT_W         = 8;

    typedef logic [2:0] state_t;

    localparam state_t ST_RESET  = 3'd0;
    localparam state_t ST_INIT   = 3'd1;
    localparam state_t ST_IDLE   = 3'd2;
    localparam state_t ST_ACTIVE = 3'd3;
    localparam state_t ST_ERROR  = 3'd4;

    // A word leaving a VC FIFO and the output FIFO it is headed for.
    typedef struct packed {
        logic                     to_d1;
        logic [DEF_BITNUMBER-1:0] word;
    } fwd_t;

    // Outside IDLE/ACTIVE the controller is not ready to accept traffic,
    // so the main FIFO is held off regardless of the almost-full flags.
    function automatic logic pause_forced(input state_t s);
        return (s == ST_RESET) || (s == ST_INIT) || (s == ST_ERROR);
    endfunction

endpackage

// File: rtl/tl_flow_ctrl_if.sv
// -----------------------------------------------------------------------------
// tl_flow_ctrl_if
// FIFO-side bundle of the flow controller.
//   Status into the controller : *_empty, *_almost_full, VC0_head, VC1_head
//   Strobes out of controller  : Main_pause, pop_VC0, pop_VC1,
//                                push_D0, push_D1, data_out
// Modports:
//   master - the flow controller
//   slave  - the FIFO array (or a testbench standing in for it)
// -----------------------------------------------------------------------------
interface tl_flow_ctrl_if #(
    parameter int BITNUMBER = tl_flow_ctrl_pkg::DEF_BITNUMBER
) ();

    logic                 MF_empty;
    logic                 VC0_empty;
    logic                 VC1_empty;
    logic                 D0_empty;
    logic                 D1_empty;
    logic                 MF_almost_full;
    logic                 VC0_almost_full;
    logic                 VC1_almost_full;
    logic                 D0_almost_full;
    logic                 D1_almost_full;
    logic [BITNUMBER-1:0] VC0_head;
    logic [BITNUMBER-1:0] VC1_head;

    logic                 Main_pause;
    logic                 pop_VC0;
    logic                 pop_VC1;
    logic                 push_D0;
    logic                 push_D1;
    logic [BITNUMBER-1:0] data_out;

    modport master (
        input  MF_empty, VC0_empty, VC1_empty, D0_empty, D1_empty,
        input  MF_almost_full, VC0_almost_full, VC1_almost_full,
        input  D0_almost_full, D1_almost_full,
        input  VC0_head, VC1_head,
        output Main_pause, pop_VC0, pop_VC1, push_D0, push_D1, data_out
    );

    modport slave (
        output MF_empty, VC0_empty, VC1_empty, D0_empty, D1_empty,
        output MF_almost_full, VC0_almost_full, VC1_almost_full,
        output D0_almost_full, D1_almost_full,
        output VC0_head, VC1_head,
        input  Main_pause, pop_VC0, pop_VC1, push_D0, push_D1, data_out
    );

endinterface

// File: rtl/tl_vc_arbiter.sv
// -----------------------------------------------------------------------------
// tl_vc_arbiter
// Purely combinational pop arbiter for the two virtual-channel FIFOs.
// A VC is eligible when the controller is ACTIVE, the VC holds a word, and the
// output FIFO selected by that word's DEST_BIT is not almost full. VC0 wins
// whenever it is eligible; a VC0 stalled on its destination leaves the slot
// free for VC1. At most one pop is raised per cycle.
// Ports:
//   active                  controller is in ACTIVE
//   vc0_empty/vc1_empty     VC FIFO empty flags
//   vc0_head/vc1_head       VC FIFO head words
//   d0/d1_almost_full       output FIFO almost-full flags
//   pop_vc0/pop_vc1         pop strobes
//   fwd_valid               a pop is being issued this cycle
//   fwd_word                the word being popped
//   fwd_to_d1               its destination (0 = D0, 1 = D1)
// -----------------------------------------------------------------------------
module tl_vc_arbiter #(
    parameter int BITNUMBER = 8,
    parameter int DEST_BIT  = 4
) (
    input  logic                 active,
    input  logic                 vc0_empty,
    input  logic                 vc1_empty,
    input  logic [BITNUMBER-1:0] vc0_head,
    input  logic [BITNUMBER-1:0] vc1_head,
    input  logic                 d0_almost_full,
    input  logic                 d1_almost_full,
    output logic                 pop_vc0,
    output logic                 pop_vc1,
    output logic                 fwd_valid,
    output logic [BITNUMBER-1:0] fwd_word,
    output logic                 fwd_to_d1
);

    logic [1:0]           vc_empty;
    logic [1:0]           vc_dest;
    logic [1:0]           vc_blocked;
    logic [1:0]           vc_eligible;
    logic [BITNUMBER-1:0] vc_head [2];

    assign vc_empty   = {vc1_empty, vc0_empty};
    assign vc_head[0] = vc0_head;
    assign vc_head[1] = vc1_head;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_vc
            assign vc_dest[gi]     = vc_head[gi][DEST_BIT];
            assign vc_blocked[gi]  = vc_dest[gi] ? d1_almost_full : d0_almost_full;
            assign vc_eligible[gi] = active & ~vc_empty[gi] & ~vc_blocked[gi];
        end
    endgenerate

    assign pop_vc0   = vc_eligible[0];
    assign pop_vc1   = vc_eligible[1] & ~vc_eligible[0];
    assign fwd_valid = pop_vc0 | pop_vc1;
    assign fwd_word  = pop_vc0 ? vc_head[0] : vc_head[1];
    assign fwd_to_d1 = pop_vc0 ? vc_dest[0] : vc_dest[1];

endmodule

// File: rtl/tl_flow_ctrl.sv
// -----------------------------------------------------------------------------
// tl_flow_ctrl
// Transaction-layer flow controller. Sequences RESET -> INIT -> IDLE/ACTIVE
// (ERROR on any FIFO fault), latches the three thresholds during INIT, moves
// words from the VC FIFOs to the D0/D1 output FIFOs through a one-stage push
// pipeline, and counts words delivered to each output.
// Ports:
//   clk, reset (async, active-low), init, fifo_error
//   Umbral_*_in / Umbral_*      threshold inputs / latched thresholds
//   state                       current FSM state (see package encodings)
//   cnt_D0, cnt_D1              forwarded-word counters (wrap at 8 bits)
//   bus (master)                FIFO status in, pause/pop/push/data out
// -----------------------------------------------------------------------------
module tl_flow_ctrl
    import tl_flow_ctrl_pkg::*;
#(
    parameter int BITNUMBER = DEF_BITNUMBER,
    parameter int LENGTH    = DEF_LENGTH,
    parameter int DEST_BIT  = DEF_DEST_BIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic [LENGTH-1:0] Umbral_MF_in,
    input  logic [LENGTH-1:0] Umbral_VC_in,
    input  logic [LENGTH-1:0] Umbral_D_in,
    input  logic              fifo_error,
    output logic [LENGTH-1:0] Umbral_MF,
    output logic [LENGTH-1:0] Umbral_VC,
    output logic [LENGTH-1:0] Umbral_D,
    output logic [2:0]        state,
    output logic [CNT_W-1:0]  cnt_D0,
    output logic [CNT_W-1:0]  cnt_D1,
    tl_flow_ctrl_if.master    bus
);

    state_t               state_q,     state_d;
    logic [LENGTH-1:0]    umbral_mf_q, umbral_mf_d;
    logic [LENGTH-1:0]    umbral_vc_q, umbral_vc_d;
    logic [LENGTH-1:0]    umbral_d_q,  umbral_d_d;
    logic [BITNUMBER-1:0] data_q,      data_d;
    logic                 push_d0_q,   push_d0_d;
    logic                 push_d1_q,   push_d1_d;
    logic [CNT_W-1:0]     cnt_d0_q,    cnt_d0_d;
    logic [CNT_W-1:0]     cnt_d1_q,    cnt_d1_d;

    logic                 any_busy;
    logic                 enter_init;
    logic                 load_thresholds;
    logic                 pop_vc0;
    logic                 pop_vc1;
    logic                 fwd_valid;
    logic [BITNUMBER-1:0] fwd_word;
    logic                 fwd_to_d1;

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    assign any_busy = ~(bus.MF_empty & bus.VC0_empty & bus.VC1_empty &
                        bus.D0_empty & bus.D1_empty);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:  state_d = ST_INIT;
            ST_INIT: begin
                if (fifo_error)    state_d = ST_ERROR;
                else if (!init)    state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (fifo_error)    state_d = ST_ERROR;
                else if (init)     state_d = ST_INIT;
                else if (any_busy) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (fifo_error)    state_d = ST_ERROR;
                else if (init)     state_d = ST_INIT;
                else if (!any_busy) state_d = ST_IDLE;
            end
            ST_ERROR:  state_d = ST_ERROR;
            // Unused encodings restart the bring-up sequence.
            default:   state_d = ST_RESET;
        endcase
    end

    assign enter_init      = (state_d == ST_INIT) && (state_q != ST_INIT);
    assign load_thresholds = (state_q == ST_INIT) && init;

    // ------------------------------------------------------------------
    // Pop arbitration
    // ------------------------------------------------------------------
    tl_vc_arbiter #(
        .BITNUMBER (BITNUMBER),
        .DEST_BIT  (DEST_BIT)
    ) u_arbiter (
        .active         (state_q == ST_ACTIVE),
        .vc0_empty      (bus.VC0_empty),
        .vc1_empty      (bus.VC1_empty),
        .vc0_head       (bus.VC0_head),
        .vc1_head       (bus.VC1_head),
        .d0_almost_full (bus.D0_almost_full),
        .d1_almost_full (bus.D1_almost_full),
        .pop_vc0        (pop_vc0),
        .pop_vc1        (pop_vc1),
        .fwd_valid      (fwd_valid),
        .fwd_word       (fwd_word),
        .fwd_to_d1      (fwd_to_d1)
    );

    // ------------------------------------------------------------------
    // Datapath next-state: thresholds, push pipeline, counters
    // ------------------------------------------------------------------
    always_comb begin
        umbral_mf_d = umbral_mf_q;
        umbral_vc_d = umbral_vc_q;
        umbral_d_d  = umbral_d_q;
        if (load_thresholds) begin
            umbral_mf_d = Umbral_MF_in;
            umbral_vc_d = Umbral_VC_in;
            umbral_d_d  = Umbral_D_in;
        end

        // The push stage is fed purely by the pop of the previous cycle, so a
        // pop in the final ACTIVE cycle still lands after the state changes.
        push_d0_d = fwd_valid & ~fwd_to_d1;
        push_d1_d = fwd_valid &  fwd_to_d1;
        data_d    = fwd_valid ? fwd_word : data_q;

        // Counters track the visible push pulses; clearing on INIT entry
        // takes precedence over a pulse still draining from before.
        cnt_d0_d = cnt_d0_q;
        cnt_d1_d = cnt_d1_q;
        if (enter_init) begin
            cnt_d0_d = '0;
            cnt_d1_d = '0;
        end else begin
            if (push_d0_q) cnt_d0_d = cnt_d0_q + 1'b1;
            if (push_d1_q) cnt_d1_d = cnt_d1_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RESET;
            umbral_mf_q <= '0;
            umbral_vc_q <= '0;
            umbral_d_q  <= '0;
            data_q      <= '0;
            push_d0_q   <= 1'b0;
            push_d1_q   <= 1'b0;
            cnt_d0_q    <= '0;
            cnt_d1_q    <= '0;
        end else begin
            state_q     <= state_d;
            umbral_mf_q <= umbral_mf_d;
            umbral_vc_q <= umbral_vc_d;
            umbral_d_q  <= umbral_d_d;
            data_q      <= data_d;
            push_d0_q   <= push_d0_d;
            push_d1_q   <= push_d1_d;
            cnt_d0_q    <= cnt_d0_d;
            cnt_d1_q    <= cnt_d1_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign state     = state_q;
    assign Umbral_MF = umbral_mf_q;
    assign Umbral_VC = umbral_vc_q;
    assign Umbral_D  = umbral_d_q;
    assign cnt_D0    = cnt_d0_q;
    assign cnt_D1    = cnt_d1_q;

    assign bus.Main_pause = pause_forced(state_q) | bus.MF_almost_full |
                            bus.VC0_almost_full | bus.VC1_almost_full;
    assign bus.pop_VC0    = pop_vc0;
    assign bus.pop_VC1    = pop_vc1;
    assign bus.push_D0    = push_d0_q;
    assign bus.push_D1    = push_d1_q;
    assign bus.data_out   = data_q;

endmodule

// File: tb/tb_tl_flow_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tl_flow_ctrl
// Directed bench for tl_flow_ctrl. Expected forwards are queued as stimulus is
// issued; a monitor process compares every push pulse against the queue head.
// State, threshold, pop and counter values are checked directly.
// -----------------------------------------------------------------------------
module tb_tl_flow_ctrl;
    import tl_flow_ctrl_pkg::*;

    localparam int BW = DEF_BITNUMBER;
    localparam int LW = DEF_LENGTH;

    logic              clk = 1'b0;
    logic              reset;
    logic              init;
    logic              fifo_error;
    logic [LW-1:0]     umf_in, uvc_in, ud_in;
    logic [LW-1:0]     Umbral_MF, Umbral_VC, Umbral_D;
    logic [2:0]        state;
    logic [CNT_W-1:0]  cnt_D0, cnt_D1;

    always #5 clk = ~clk;

    tl_flow_ctrl_if #(.BITNUMBER(BW)) bus ();

    tl_flow_ctrl #(
        .BITNUMBER (BW),
        .LENGTH    (LW),
        .DEST_BIT  (DEF_DEST_BIT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .init         (init),
        .Umbral_MF_in (umf_in),
        .Umbral_VC_in (uvc_in),
        .Umbral_D_in  (ud_in),
        .fifo_error   (fifo_error),
        .Umbral_MF    (Umbral_MF),
        .Umbral_VC    (Umbral_VC),
        .Umbral_D     (Umbral_D),
        .state        (state),
        .cnt_D0       (cnt_D0),
        .cnt_D1       (cnt_D1),
        .bus          (bus.master)
    );

    fwd_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_fwd(input logic to_d1, input logic [BW-1:0] word);
        fwd_t e;
        e.to_d1 = to_d1;
        e.word  = word;
        exp_q.push_back(e);
    endtask

    initial begin
        reset      = 1'b0;
        init       = 1'b0;
        fifo_error = 1'b0;
        umf_in     = '0;
        uvc_in     = '0;
        ud_in      = '0;
        bus.MF_empty = 1'b1;  bus.VC0_empty = 1'b0; bus.VC1_empty = 1'b0;
        bus.D0_empty = 1'b1;  bus.D1_empty  = 1'b1;
        bus.MF_almost_full  = 1'b0; bus.VC0_almost_full = 1'b0;
        bus.VC1_almost_full = 1'b0; bus.D0_almost_full  = 1'b0;
        bus.D1_almost_full  = 1'b0;
        bus.VC0_head = 8'h01;
        bus.VC1_head = 8'h02;

        // Scoreboard monitor: every push pulse must match the oldest expectation.
        fork
            forever begin
                fwd_t e;
                @(negedge clk);
                if (reset === 1'b1 && (bus.push_D0 === 1'b1 || bus.push_D1 === 1'b1)) begin
                    if (bus.push_D0 === 1'b1 && bus.push_D1 === 1'b1) begin
                        check("push_onehot", 32'({bus.push_D1, bus.push_D0}), 32'd1);
                    end else if (exp_q.size() == 0) begin
                        check("unexpected_push_data", 32'(bus.data_out), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("fwd_dest_d1", 32'(bus.push_D1), 32'(e.to_d1));
                        check("fwd_data", 32'(bus.data_out), 32'(e.word));
                    end
                end
            end
        join_none

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        check("rst_state",      32'(state), 32'(ST_RESET));
        check("rst_pause",      32'(bus.Main_pause), 1);
        check("rst_pop_vc0",    32'(bus.pop_VC0), 0);
        check("rst_pop_vc1",    32'(bus.pop_VC1), 0);
        check("rst_umbral_mf",  32'(Umbral_MF), 0);
        check("rst_data_out",   32'(bus.data_out), 0);
        check("rst_cnt_d0",     32'(cnt_D0), 0);
        check("rst_push",       32'({bus.push_D1, bus.push_D0}), 0);

        // ---------------- bring-up: RESET -> INIT -> IDLE ----------------
        reset = 1'b1; init = 1'b1;
        umf_in = 8'd1; uvc_in = 8'd2; ud_in = 8'd3;
        bus.VC0_empty = 1'b1; bus.VC1_empty = 1'b1;
        tick();
        check("bringup_state_init", 32'(state), 32'(ST_INIT));
        check("bringup_pause_init", 32'(bus.Main_pause), 1);
        tick();
        init = 1'b0;
        check("bringup_still_init", 32'(state), 32'(ST_INIT));
        check("umbral_mf", 32'(Umbral_MF), 1);
        check("umbral_vc", 32'(Umbral_VC), 2);
        check("umbral_d",  32'(Umbral_D),  3);
        tick();
        check("bringup_state_idle", 32'(state), 32'(ST_IDLE));
        check("idle_pause",         32'(bus.Main_pause), 0);
        bus.VC1_almost_full = 1'b1;
        #1;
        check("idle_pause_vc1_af",  32'(bus.Main_pause), 1);
        bus.VC1_almost_full = 1'b0;

        // ---------------- VC0 priority over VC1 ----------------
        bus.VC0_head = 8'h10; bus.VC0_empty = 1'b0;
        bus.VC1_head = 8'h05; bus.VC1_empty = 1'b0;
        #1;
        check("idle_no_pop", 32'(bus.pop_VC0), 0);
        tick();
        check("prio_state_active", 32'(state), 32'(ST_ACTIVE));
        check("prio_pop_vc0", 32'(bus.pop_VC0), 1);
        check("prio_pop_vc1", 32'(bus.pop_VC1), 0);
        expect_fwd(1'b1, 8'h10);
        tick();
        bus.VC0_empty = 1'b1;
        #1;
        check("prio_vc1_after_vc0", 32'(bus.pop_VC1), 1);
        check("prio_vc0_idle",      32'(bus.pop_VC0), 0);
        expect_fwd(1'b0, 8'h05);
        tick();
        bus.VC1_empty = 1'b1;
        #1;
        check("prio_drained_no_pop", 32'(bus.pop_VC1), 0);
        tick();
        check("prio_back_idle", 32'(state), 32'(ST_IDLE));
        check("data_out_hold",  32'(bus.data_out), 32'h05);

        // ---------------- blocked VC0 does not block VC1 ----------------
        bus.D1_almost_full = 1'b1;
        bus.VC0_head = 8'h10; bus.VC0_empty = 1'b0;
        bus.VC1_head = 8'h03; bus.VC1_empty = 1'b0;
        tick();
        check("blk_pop_vc0", 32'(bus.pop_VC0), 0);
        check("blk_pop_vc1", 32'(bus.pop_VC1), 1);
        expect_fwd(1'b0, 8'h03);
        tick();
        bus.VC1_empty = 1'b1;
        #1;
        check("blk_pop_vc0_held", 32'(bus.pop_VC0), 0);
        check("blk_state_active", 32'(state), 32'(ST_ACTIVE));
        bus.VC0_empty = 1'b1;
        bus.D1_almost_full = 1'b0;
        tick();
        check("blk_back_idle", 32'(state), 32'(ST_IDLE));
        check("cnt_d0_after_two", 32'(cnt_D0), 2);
        check("cnt_d1_after_one", 32'(cnt_D1), 1);

        // ---------------- re-init from IDLE clears counters ----------------
        init = 1'b1;
        umf_in = 8'd4; uvc_in = 8'd5; ud_in = 8'd6;
        tick();
        check("reinit_state", 32'(state), 32'(ST_INIT));
        check("reinit_cnt_d0", 32'(cnt_D0), 0);
        check("reinit_cnt_d1", 32'(cnt_D1), 0);
        tick();
        init = 1'b0;
        tick();
        check("reinit_idle", 32'(state), 32'(ST_IDLE));
        check("reinit_umbral_mf", 32'(Umbral_MF), 4);
        check("reinit_umbral_vc", 32'(Umbral_VC), 5);
        check("reinit_umbral_d",  32'(Umbral_D),  6);

        // ---------------- 256 forwards to D0: counter wrap ----------------
        bus.VC0_head = 8'h00; bus.VC0_empty = 1'b0;
        tick();
        for (int i = 0; i < 256; i++) begin
            bus.VC0_head = 8'(i) & 8'hEF;
            expect_fwd(1'b0, 8'(i) & 8'hEF);
            tick();
        end
        check("wrap_cnt_d0_255", 32'(cnt_D0), 255);
        bus.VC0_empty = 1'b1;
        tick();
        check("wrap_cnt_d0_0", 32'(cnt_D0), 0);
        check("wrap_cnt_d1_0", 32'(cnt_D1), 0);

        bus.VC0_head = 8'h10; bus.VC0_empty = 1'b0;
        bus.VC1_head = 8'h02; bus.VC1_empty = 1'b0;
        tick();
        expect_fwd(1'b1, 8'h10);
        tick();
        bus.VC0_empty = 1'b1;
        expect_fwd(1'b0, 8'h02);
        tick();
        bus.VC1_empty = 1'b1;
        tick();
        check("post_wrap_cnt_d0", 32'(cnt_D0), 1);
        check("post_wrap_cnt_d1", 32'(cnt_D1), 1);
        init = 1'b1;
        tick();
        check("clr_cnt_d0", 32'(cnt_D0), 0);
        check("clr_cnt_d1", 32'(cnt_D1), 0);
        init = 1'b0;
        tick();

        // ---------------- fifo_error: sticky ERROR ----------------
        bus.VC0_head = 8'h01; bus.VC0_empty = 1'b0;
        tick();
        check("err_pre_pop", 32'(bus.pop_VC0), 1);
        expect_fwd(1'b0, 8'h01);
        fifo_error = 1'b1;
        tick();
        fifo_error = 1'b0;
        check("err_state",  32'(state), 32'(ST_ERROR));
        check("err_no_pop", 32'(bus.pop_VC0), 0);
        check("err_pause",  32'(bus.Main_pause), 1);
        init = 1'b1;
        tick();
        init = 1'b0;
        repeat (2) tick();
        check("err_sticky", 32'(state), 32'(ST_ERROR));
        check("err_sticky_no_pop", 32'(bus.pop_VC0), 0);

        // ---------------- reset mid-transfer cancels the push ----------------
        reset = 1'b0;
        bus.VC0_empty = 1'b1;
        #1;
        check("err_reset_state", 32'(state), 32'(ST_RESET));
        tick();
        reset = 1'b1; init = 1'b1;
        tick();
        init = 1'b0;
        tick();
        bus.VC0_head = 8'h12; bus.VC0_empty = 1'b0;
        tick();
        check("mid_pop", 32'(bus.pop_VC0), 1);
        tick();
        check("mid_push_before_reset", 32'(bus.push_D1), 1);
        reset = 1'b0;
        #1;
        check("mid_push_cancelled", 32'({bus.push_D1, bus.push_D0}), 0);
        check("mid_data_cleared",   32'(bus.data_out), 0);
        check("mid_state_reset",    32'(state), 32'(ST_RESET));
        check("mid_pop_blocked",    32'(bus.pop_VC0), 0);
        bus.VC0_empty = 1'b1;
        repeat (2) tick();

        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
